// File: rtl/snell_law_pkg.sv
// Shared definitions for the Snell's-law index solver.
// Widths, angle/index limits, the FSM state type, and the quarter-wave
// sine table in Q0.16 (entry k = round(65535*sin(k deg))).
package snell_law_pkg;

  localparam int IDX_W   = 4;
  localparam int ANG_W   = 7;
  localparam int SIN_W   = 16;
  localparam int NUM_W   = 20;
  localparam int ANG_MAX = 90;
  localparam int N_MAX   = 15;
  localparam int DIV_CYC = 20;   // one quotient bit per cycle
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {IDLE, LOOKUP, DIV, DONE} state_t;

  localparam int SIN_TAB [0:ANG_MAX] = '{
        0,  1144,  2287,  3430,  4571,  5712,  6850,  7987,  9121, 10252,
    11380, 12505, 13625, 14742, 15854, 16962, 18064, 19161, 20251, 21336,
    22414, 23486, 24550, 25607, 26655, 27696, 28729, 29752, 30767, 31772,
    32768, 33753, 34728, 35693, 36647, 37589, 38521, 39440, 40347, 41243,
    42125, 42995, 43851, 44695, 45524, 46340, 47142, 47929, 48702, 49460,
    50203, 50930, 51642, 52339, 53019, 53683, 54331, 54962, 55577, 56174,
    56755, 57318, 57864, 58392, 58902, 59395, 59869, 60325, 60763, 61182,
    61583, 61965, 62327, 62671, 62996, 63302, 63588, 63855, 64103, 64331,
    64539, 64728, 64897, 65047, 65176, 65286, 65375, 65445, 65495, 65525,
    65535
  };

  // Angles past 90 deg fold onto the table end before lookup.
  function automatic logic [SIN_W-1:0] sin_lut(input logic [ANG_W-1:0] ang);
    logic [ANG_W-1:0] a;
    a = (ang > ANG_W'(ANG_MAX)) ? ANG_W'(ANG_MAX) : ang;
    return SIN_W'(SIN_TAB[a]);
  endfunction

endpackage

// File: rtl/snell_div.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
//   start       : load operands and perform the first step this edge
//   numerator   : NUM_W-bit dividend
//   denominator : SIN_W-bit divisor (caller handles zero)
//   quotient    : NUM_W-bit quotient
//   remainder   : SIN_W-bit remainder
//   done        : high once all DIV_CYC steps have completed
module snell_div
  import snell_law_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [SIN_W-1:0] denominator,
  output logic [NUM_W-1:0] quotient,
  output logic [SIN_W-1:0] remainder,
  output logic             done
);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [SIN_W-1:0] src_r, nxt_r;
  logic [NUM_W-1:0] src_q, nxt_q;
  logic [SIN_W:0]   trial, diff;
  logic             ge;

  // On start the step operates on the fresh operands, so the first
  // quotient bit is produced on the load edge itself.
  always_comb begin
    src_r = start ? '0 : remainder;
    src_q = start ? numerator : quotient;
    trial = {src_r, src_q[NUM_W-1]};
    diff  = trial - {1'b0, denominator};
    ge    = (trial >= {1'b0, denominator});
    nxt_r = ge ? diff[SIN_W-1:0] : trial[SIN_W-1:0];
    nxt_q = {src_q[NUM_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      quotient  <= nxt_q;
      remainder <= nxt_r;
      cnt       <= CNT_W'(1);
      busy      <= 1'b1;
      done      <= 1'b0;
    end else if (busy) begin
      quotient  <= nxt_q;
      remainder <= nxt_r;
      cnt       <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(DIV_CYC - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/snell_law.sv
// Solves Snell's law for the medium-1 index:
//   n1 = round(n2*sin(theeta2)/sin(theeta1)), saturated to N_MAX.
// Free-running 23-cycle loop IDLE -> LOOKUP -> DIV(20) -> DONE.
//   clk, rst      : clock, async active-low reset
//   n2            : medium-2 index, 0..15
//   theeta1/2     : incidence / refraction angles in degrees, 0..127
//   n1            : registered result, updated every 23 clocks
module snell_law
  import snell_law_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] n2,
  input  logic [ANG_W-1:0] theeta1,
  input  logic [ANG_W-1:0] theeta2,
  output logic [IDX_W-1:0] n1
);

  state_t           state;
  logic [IDX_W-1:0] n2_q, res_q;
  logic [ANG_W-1:0] t1_q, t2_q;
  logic [NUM_W-1:0] num_q, quo;
  logic [SIN_W-1:0] den_q, rem;
  logic [CNT_W-1:0] cnt;
  logic             res_vld, div_start, div_done;
  logic [NUM_W:0]   q_rnd;
  logic [IDX_W-1:0] fin;

  assign div_start = (state == DIV) && (cnt == '0) && (den_q != '0);

  snell_div u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .numerator   (num_q),
    .denominator (den_q),
    .quotient    (quo),
    .remainder   (rem),
    .done        (div_done)
  );

  // Round half up on 2r >= d, then saturate; zero divisor bypasses the divider.
  always_comb begin
    q_rnd = (NUM_W+1)'(quo) +
            (NUM_W+1)'(({rem, 1'b0} >= {1'b0, den_q}) ? 1 : 0);
    if (den_q == '0)
      fin = (num_q != '0) ? IDX_W'(N_MAX) : '0;
    else if (q_rnd > (NUM_W+1)'(N_MAX))
      fin = IDX_W'(N_MAX);
    else
      fin = q_rnd[IDX_W-1:0];
  end

  // The DONE result is held in res_q and moved to n1 on the following
  // IDLE edge, which lands exactly 23 clocks after its own sampling edge.
  // res_vld keeps the first loop after reset from publishing anything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      n2_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      num_q   <= '0;
      den_q   <= '0;
      cnt     <= '0;
      res_q   <= '0;
      res_vld <= 1'b0;
      n1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          n2_q  <= n2;
          t1_q  <= theeta1;
          t2_q  <= theeta2;
          if (res_vld) n1 <= res_q;
          state <= LOOKUP;
        end
        LOOKUP: begin
          num_q <= NUM_W'(n2_q) * NUM_W'(sin_lut(t2_q));
          den_q <= sin_lut(t1_q);
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_CYC - 1)) state <= DONE;
        end
        DONE: begin
          res_q   <= fin;
          res_vld <= div_done || (den_q == '0);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snell_law.sv
// Directed bench for snell_law. Each vector is sampled on an IDLE edge;
// its result is checked 23 clocks later (that edge is also the next
// vector's sampling edge), with a hold check one clock before.
module tb_snell_law;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] n2;
  logic [6:0] theeta1, theeta2;
  logic [3:0] n1;

  int total = 0;
  int bad   = 0;

  logic [3:0] pend_exp;
  string      pend_tag;

  snell_law dut (
    .clk     (clk),
    .rst     (rst),
    .n2      (n2),
    .theeta1 (theeta1),
    .theeta2 (theeta2),
    .n1      (n1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge just before a sampling edge. Optionally changes
  // the inputs mid-DIV to show they are ignored until the next IDLE.
  task automatic vec(input string tag, input logic [3:0] a, input logic [6:0] b,
                     input logic [6:0] c, input logic [3:0] exp, input bit chg,
                     input logic [3:0] a2, input logic [6:0] b2, input logic [6:0] c2);
    n2 = a; theeta1 = b; theeta2 = c;
    @(posedge clk);
    #1 chk({pend_tag, "_out"}, n1, pend_exp);
    if (chg) begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      n2 = a2; theeta1 = b2; theeta2 = c2;
      repeat (17) @(posedge clk);
    end else begin
      repeat (22) @(posedge clk);
    end
    #1 chk({pend_tag, "_hold"}, n1, pend_exp);
    @(negedge clk);
    pend_exp = exp;
    pend_tag = tag;
  endtask

  initial begin
    rst = 1'b0; n2 = 4'd11; theeta1 = 7'd1; theeta2 = 7'd1;
    repeat (3) @(negedge clk);
    chk("rst_n1", n1, 4'd0);
    rst = 1'b1;
    pend_exp = 4'd0;
    pend_tag = "post_rst";

    vec("one",   4'd11, 7'd1,   7'd1,   4'd11, 1'b0, 4'd0, 7'd0, 7'd0);
    vec("half",  4'd10, 7'd90,  7'd30,  4'd5,  1'b0, 4'd0, 7'd0, 7'd0);
    vec("round", 4'd3,  7'd30,  7'd90,  4'd6,  1'b0, 4'd0, 7'd0, 7'd0);
    vec("sat",   4'd1,  7'd1,   7'd90,  4'd15, 1'b0, 4'd0, 7'd0, 7'd0);
    vec("dz_nz", 4'd5,  7'd0,   7'd45,  4'd15, 1'b0, 4'd0, 7'd0, 7'd0);
    vec("dz_z",  4'd0,  7'd0,   7'd45,  4'd0,  1'b0, 4'd0, 7'd0, 7'd0);
    vec("clamp", 4'd7,  7'd120, 7'd127, 4'd7,  1'b0, 4'd0, 7'd0, 7'd0);
    // 15*32768/46340 = 10 r 28120, 2r >= d -> 11
    vec("t45",   4'd15, 7'd45,  7'd30,  4'd11, 1'b0, 4'd0, 7'd0, 7'd0);
    vec("chg_a", 4'd10, 7'd90,  7'd30,  4'd5,  1'b1, 4'd3, 7'd30, 7'd90);
    vec("chg_b", 4'd3,  7'd30,  7'd90,  4'd6,  1'b0, 4'd0, 7'd0, 7'd0);

    // Reset in the middle of DIV: n1 clears at once, nothing partial survives.
    n2 = 4'd11; theeta1 = 7'd1; theeta2 = 7'd1;
    @(posedge clk);
    #1 chk({pend_tag, "_out"}, n1, pend_exp);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid", n1, 4'd0);
    repeat (2) @(negedge clk);
    chk("rst_mid_hold", n1, 4'd0);
    rst = 1'b1;
    pend_exp = 4'd0;
    pend_tag = "rst_rel";
    vec("after_rst", 4'd11, 7'd1, 7'd1, 4'd11, 1'b0, 4'd0, 7'd0, 7'd0);

    @(posedge clk);
    #1 chk({pend_tag, "_out"}, n1, pend_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snell_law.md
SNELL_LAW -- requirements
Module: snell_law

Interface
REQ-001 Parameters: none; all widths and constants are fixed in the package (REQ-021).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low (rst=0 resets).
REQ-005 n2  input  4  refractive index of medium 2, unsigned integer 0..15.
REQ-006 theeta1  input  7  incidence angle in degrees, unsigned 0..127.
REQ-007 theeta2  input  7  refraction angle in degrees, unsigned 0..127.
REQ-008 n1  output  4  computed index of medium 1, unsigned integer, registered.

Function
REQ-009 n1 SHALL be round(n2*sin(theeta2)/sin(theeta1)), saturated to 15.
REQ-010 Angles above 90 SHALL be clamped to 90 before lookup.
REQ-011 Sine SHALL come from a 91-entry LUT, 16-bit unsigned Q0.16: entry k = round(65535*sin(k deg)), so sin0=0, sin1=1144, sin30=32768, sin90=65535.
REQ-012 Numerator = n2*sin(theeta2) (20 bits unsigned); denominator = sin(theeta1) (16 bits).
REQ-013 FSM states: IDLE, LOOKUP, DIV, DONE; IDLE->LOOKUP->DIV->DONE->IDLE, unconditional.
REQ-014 IDLE (1 cycle): register n2, theeta1, theeta2.
REQ-015 LOOKUP (1 cycle): clamp, LUT read, multiply; register numerator and denominator.
REQ-016 DIV (20 cycles): restoring division, one quotient bit per cycle, MSB first; 20-bit quotient q, 16-bit remainder r.
REQ-017 DONE (1 cycle): if 2r >= denominator then q=q+1; if q>15 then n1=15, else n1=q[3:0]; return to IDLE.
REQ-018 Divide-by-zero (denominator 0): n1=15 if numerator non-zero, n1=0 if numerator zero; no division performed, FSM timing unchanged.
REQ-019 Latency: n1 updates exactly 23 clocks after the IDLE sampling edge; computation repeats continuously, so a new result is produced every 23 clocks.
REQ-020 Input changes after the IDLE sampling edge SHALL be ignored until the next IDLE; n1 holds its value between DONE updates.

Structure
REQ-021 Package snell_law_pkg SHALL hold the sine LUT (constant array or function), the FSM state enum, widths (IDX_W=4, ANG_W=7, SIN_W=16, NUM_W=20), ANG_MAX=90, and N_MAX=15.
REQ-022 The sequential divider SHALL be a sub-module snell_div (start, numerator, denominator, quotient, remainder, done).
REQ-023 n1 SHALL be driven directly from a flip-flop, with no combinational path from any input.

Reset
REQ-024 While rst=0: n1=0, FSM=IDLE, all datapath and divider registers=0, asynchronously.
REQ-025 Reset asserted mid-computation SHALL abort the computation, leaving no partial result on n1.
REQ-026 After rst deasserts, the first sampling SHALL occur on the first rising edge; the first valid n1 appears 23 clocks later.

Verification
REQ-027 n2=11, theeta1=1, theeta2=1 -> n1=11 after 23 clocks.
REQ-028 n2=10, theeta1=90, theeta2=30 -> n1=5; n2=3, theeta1=30, theeta2=90 -> n1=6 (rounding).
REQ-029 n2=1, theeta1=1, theeta2=90 -> n1=15 (saturation); n2=5, theeta1=0, theeta2=45 -> n1=15; n2=0, theeta1=0 -> n1=0.
REQ-030 theeta1=120, theeta2=127, n2=7 -> n1=7 (both angles clamp to 90).
REQ-031 Change the inputs during DIV -> n1 reflects the old inputs at the next DONE and the new inputs one full cycle later.
REQ-032 Assert rst mid-DIV -> n1=0 immediately; after release, the correct result appears 23 clocks after the first sampling edge.
